// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised in-order-retire reorder buffer; optional ROB_BYPASS_EN adds writeback-to-lookup bypass
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic [1:0]        alloc_kind,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              full,
    output logic              empty,
    output logic [TAG_W:0]    count,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_value,
    input  logic              wb0_redirect,
    input  logic [DATA_W-1:0] wb0_target,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_value,
    input  logic              wb2_valid,
    input  logic [TAG_W-1:0]  wb2_tag,
    input  logic [TAG_W-1:0]  rs1_tag,
    input  logic [TAG_W-1:0]  rs2_tag,
    output logic              rs1_ready,
    output logic              rs2_ready,
    output logic [DATA_W-1:0] rs1_value,
    output logic [DATA_W-1:0] rs2_value,
    output logic              commit_reg_valid,
    output logic [REG_W-1:0]  commit_reg_dest,
    output logic [DATA_W-1:0] commit_reg_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              commit_store_valid,
    input  logic              commit_store_ack,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc
);
    typedef enum logic [1:0] {K_REG, K_STORE, K_BRANCH, K_JALR} kind_e;
    typedef enum logic {S_IDLE, S_STORE_WAIT} state_e;

    state_e state, state_nx;
    logic [TAG_W-1:0] head, tail;
    logic [DEPTH-1:0] busy, ent_ready, ent_redirect;
    kind_e            ent_kind   [DEPTH];
    logic [REG_W-1:0] ent_dest   [DEPTH];
    logic [DATA_W-1:0] ent_value [DEPTH];
    logic [DATA_W-1:0] ent_target[DEPTH];

    logic head_ok, pop, do_reg, do_flush, alloc_fire;

    assign alloc_tag          = tail;
    assign full               = (count == (TAG_W+1)'(DEPTH));
    assign empty              = (count == '0);
    assign head_ok            = !empty && ent_ready[head];
    assign alloc_fire         = rdy && alloc_valid && !full && !do_flush;
    assign commit_store_valid = (state == S_STORE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        do_reg   = 1'b0;
        do_flush = 1'b0;
        if (rdy && head_ok) begin
            case (state)
                S_IDLE: begin
                    case (ent_kind[head])
                        K_REG:    begin do_reg = 1'b1; pop = 1'b1; end
                        K_STORE:  state_nx = S_STORE_WAIT;
                        K_BRANCH: begin
                            if (ent_redirect[head]) do_flush = 1'b1;
                            else                    pop      = 1'b1;
                        end
                        default: begin
                            do_reg = 1'b1;
                            if (ent_redirect[head]) do_flush = 1'b1;
                            else                    pop      = 1'b1;
                        end
                    endcase
                end
                default: begin
                    if (commit_store_ack) begin
                        pop      = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            endcase
        end
        if (do_flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            commit_reg_valid <= 1'b0;
            commit_reg_dest  <= '0;
            commit_reg_value <= '0;
            commit_tag       <= '0;
            flush            <= 1'b0;
            flush_pc         <= '0;
        end else if (!rdy) begin
            commit_reg_valid <= 1'b0;
            flush            <= 1'b0;
        end else begin
            commit_reg_valid <= do_reg;
            flush            <= do_flush;
            if (do_reg) begin
                commit_reg_dest  <= ent_dest[head];
                commit_reg_value <= ent_value[head];
            end
            if (pop || do_reg || do_flush) commit_tag <= head;
            if (do_flush) begin
                flush_pc <= ent_target[head];
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                busy     <= '0;
            end else begin
                if (pop) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                if (alloc_fire) begin
                    busy[tail] <= 1'b1;
                    tail       <= tail + 1'b1;
                end
                count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, pop};
            end
        end
    end

    // Payload needs no reset: busy gates every use of it.
    always_ff @(posedge clk) begin
        if (rdy && !do_flush) begin
            if (alloc_fire) begin
                ent_kind[tail]     <= kind_e'(alloc_kind);
                ent_dest[tail]     <= alloc_dest;
                ent_ready[tail]    <= 1'b0;
                ent_redirect[tail] <= 1'b0;
            end
            if (wb0_valid && busy[wb0_tag]) begin
                ent_ready[wb0_tag]    <= 1'b1;
                ent_value[wb0_tag]    <= wb0_value;
                ent_redirect[wb0_tag] <= wb0_redirect;
                ent_target[wb0_tag]   <= wb0_target;
            end
            if (wb1_valid && busy[wb1_tag]) begin
                ent_ready[wb1_tag] <= 1'b1;
                ent_value[wb1_tag] <= wb1_value;
            end
            if (wb2_valid && busy[wb2_tag]) ent_ready[wb2_tag] <= 1'b1;
        end
    end

    always_comb begin
        rs1_ready = busy[rs1_tag] && ent_ready[rs1_tag];
        rs1_value = ent_value[rs1_tag];
        rs2_ready = busy[rs2_tag] && ent_ready[rs2_tag];
        rs2_value = ent_value[rs2_tag];
`ifdef ROB_BYPASS_EN
        if (wb1_valid && busy[rs1_tag] && wb1_tag == rs1_tag) begin rs1_ready = 1'b1; rs1_value = wb1_value; end
        if (wb0_valid && busy[rs1_tag] && wb0_tag == rs1_tag) begin rs1_ready = 1'b1; rs1_value = wb0_value; end
        if (wb1_valid && busy[rs2_tag] && wb1_tag == rs2_tag) begin rs2_ready = 1'b1; rs2_value = wb1_value; end
        if (wb0_valid && busy[rs2_tag] && wb0_tag == rs2_tag) begin rs2_ready = 1'b1; rs2_value = wb0_value; end
`endif
    end
endmodule
